// File: rtl/button_pkg.sv
// Shared definitions for board pushbutton handling: debounce FSM states and
// the millisecond-to-cycle conversion.
package button_pkg;

    localparam int unsigned MS_PER_S = 1000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Number of clk cycles in a given number of milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return clk_hz / MS_PER_S * ms;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Pushbutton raw input and debounced event outputs, bundled for the debouncer.
interface button_debounce_if;

    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability-settling chain; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Pushbutton debouncer: synchronizes the raw button, requires DB_CYCLES of
// stable level before changing the debounced state, and emits one-cycle
// press/release strobes. Long-press detection is enabled by defining
// BUTTON_DEBOUNCE_LONG_PRESS_EN; otherwise long_pulse is tied low.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned DEBOUNCE_MS    = 10,
    parameter int unsigned LONG_MS        = 1000,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    button_debounce_if.slave  bus
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
    localparam int unsigned CNT_W       = ($clog2(DB_CYCLES) > 0) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Reject configurations where debounce or long-press timing is meaningless.
    if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_cfg_check
        $error("button_debounce: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
    end

    logic btn_raw_sync;
    logic btn_sync;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level, level_nxt;
    logic             press, press_nxt;
    logic             release_q, release_nxt;

    // Raw button is synchronized at its idle level so reset looks unpressed.
    sync_2ff #(
        .RESET_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.btn_in),
        .q   (btn_raw_sync)
    );

    // Normalize polarity: 1 = pressed.
    assign btn_sync = btn_raw_sync ^ BTN_ACTIVE_LOW;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            level     <= 1'b0;
            press     <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level     <= level_nxt;
            press     <= press_nxt;
            release_q <= release_nxt;
        end
    end

    // Debounce transitions; a bounce during release waiting returns to
    // PRESSED silently so a single press yields a single press strobe.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.btn_level     = level;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic              long_q, long_nxt;

    // Hold counter and long-press strobe registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            long_q   <= long_nxt;
        end
    end

    // Hold time accrues only in PRESSED and restarts only on a fresh press.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        long_nxt     = 1'b0;
        if (state == PRESS_WAIT && state_nxt == PRESSED) begin
            hold_cnt_nxt = '0;
        end else if (state == PRESSED && hold_cnt != HOLD_MAX) begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            long_nxt     = (hold_cnt == HOLD_LAST);
        end
    end

    assign bus.long_pulse = long_q;
`else
    assign bus.long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a run-length reference model predicts
// the debounced level and strobe events; a monitor compares them cycle by cycle.
module tb_button_debounce;

    localparam int unsigned DB   = 1000 / 1000 * 5;
    localparam int unsigned LONG = 1000 / 1000 * 20;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef struct {
        int cyc;
        int kind;   // 0 press, 1 release, 2 long
    } ev_t;

    typedef struct {
        int cyc;
        bit lvl;
    } lv_t;

    logic clk;
    logic rst;
    int   cyc   = 0;
    logic rst_q = 1'b0;
    bit   running = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    ev_t ev_q[$];
    lv_t lv_q[$];

    // Reference model state: synchronizer delay line, debounced level,
    // length of the current run of samples disagreeing with that level,
    // and cycles spent settled in the pressed state since the last press.
    bit m_pipe[2];
    bit m_level;
    int m_run;
    int m_hold;

    button_debounce_if bif();

    button_debounce #(
        .CLK_FREQ_HZ    (1000),
        .DEBOUNCE_MS    (5),
        .LONG_MS        (20),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Predict DUT outputs after the next posedge given the inputs it will sample.
    function automatic void model_edge(input bit r, input bit b);
        int e;
        bit s;
        bit settled;
        e = cyc + 1;
        if (!r) begin
            m_pipe[0] = 1'b0;
            m_pipe[1] = 1'b0;
            m_level   = 1'b0;
            m_run     = 0;
            m_hold    = 0;
        end else begin
            s         = m_pipe[1];
            settled   = m_level && (m_run == 0);
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = ~b;
            if (LONG_EN && settled && m_hold < LONG) begin
                m_hold++;
                if (m_hold == LONG) ev_q.push_back('{e, 2});
            end
            m_run = (s != m_level) ? m_run + 1 : 0;
            if (m_run == DB + 1) begin
                m_level = ~m_level;
                m_run   = 0;
                if (m_level) begin
                    m_hold = 0;
                    ev_q.push_back('{e, 0});
                end else begin
                    ev_q.push_back('{e, 1});
                end
            end
        end
        lv_q.push_back('{e, m_level});
    endfunction

    task automatic step(input bit r, input bit b);
        rst        = r;
        bif.btn_in = b;
        model_edge(r, b);
        @(negedge clk);
    endtask

    task automatic hold_btn(input bit b, input int n);
        for (int i = 0; i < n; i++) step(1'b1, b);
    endtask

    // Monitor: compare level every cycle and every strobe against the scoreboard.
    always @(negedge clk) begin
        automatic int np;
        automatic int kind;
        automatic lv_t lv;
        automatic ev_t ev;
        if (running && cyc > 0) begin
            np = int'(bif.press_pulse) + int'(bif.release_pulse) + int'(bif.long_pulse);
            if (!rst_q) begin
                n_tests++;
                if (bif.btn_level !== 1'b0 || np != 0) begin
                    n_fail++;
                    $display("FAIL reset_outputs @%0d: level=%0b pulses=%0d, required 0/0",
                             cyc, bif.btn_level, np);
                end
            end
            n_tests++;
            if (lv_q.size() == 0) begin
                n_fail++;
                $display("FAIL level_queue @%0d: no expectation, required one", cyc);
            end else begin
                lv = lv_q.pop_front();
                if (lv.cyc != cyc || bif.btn_level !== lv.lvl) begin
                    n_fail++;
                    $display("FAIL btn_level @%0d: got %0b, required %0b (exp cyc %0d)",
                             cyc, bif.btn_level, lv.lvl, lv.cyc);
                end
            end
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                ev = ev_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missing_pulse @%0d: kind %0d not seen, required at %0d",
                         cyc, ev.kind, ev.cyc);
            end
            if (np > 1) begin
                n_tests++;
                n_fail++;
                $display("FAIL pulse_overlap @%0d: %0d strobes high, required at most 1", cyc, np);
            end
            if (np > 0) begin
                kind = bif.press_pulse ? 0 : (bif.release_pulse ? 1 : 2);
                n_tests++;
                if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse @%0d: kind %0d, required none", cyc, kind);
                end else begin
                    ev = ev_q.pop_front();
                    if (ev.kind != kind) begin
                        n_fail++;
                        $display("FAIL pulse_kind @%0d: got %0d, required %0d", cyc, kind, ev.kind);
                    end
                end
            end
        end
    end

    initial begin
        int len;
        bit b;
        rst        = 1'b0;
        bif.btn_in = 1'b1;

        // Reset with button released.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        hold_btn(1'b1, 6);

        // Clean press held long enough for a long press, then clean release.
        hold_btn(1'b0, 40);
        hold_btn(1'b1, 20);

        // Bounce shorter than the debounce window: no events.
        hold_btn(1'b0, 3);
        hold_btn(1'b1, 2);
        hold_btn(1'b0, 3);
        hold_btn(1'b1, 15);

        // Press, then bounce back during release wait; hold count continues.
        hold_btn(1'b0, 15);
        hold_btn(1'b1, 3);
        hold_btn(1'b0, 25);
        hold_btn(1'b1, 15);

        // Reset mid-press with button kept down: fresh press afterwards.
        hold_btn(1'b0, 12);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        hold_btn(1'b0, 20);
        hold_btn(1'b1, 15);

        // Randomized bouncing and holds with occasional resets.
        for (int seg = 0; seg < 250; seg++) begin
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 3) begin
                len = int'($urandom_range(1, 3));
                for (int i = 0; i < len; i++) step(1'b0, b);
            end else begin
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 35))
                                                  : int'($urandom_range(1, 8));
                hold_btn(b, len);
            end
        end

        // Settle released and stop checking.
        hold_btn(1'b1, 20);
        @(posedge clk);
        running = 1'b0;

        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_events: %0d pending, required 0", ev_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
